// File: rtl/scanline_pp_engine.sv
// Scanline / border-mask post-process pipeline for the output pixel path, fixed 4-cycle latency.
// Optional macro SL_ALT_FIELD_EN: on odd fields the line scanline phase is shifted by one.
module scanline_pp_engine #(
  parameter int BPC    = 8,
  parameter int PHASES = 6
) (
  input  logic                  PCLK_i,
  input  logic                  reset_n,
  input  logic [BPC-1:0]        R_i,
  input  logic [BPC-1:0]        G_i,
  input  logic [BPC-1:0]        B_i,
  input  logic                  HSYNC_i,
  input  logic                  VSYNC_i,
  input  logic                  DE_i,
  input  logic [10:0]           xpos_i,
  input  logic [10:0]           ypos_i,
  input  logic                  field_i,
  input  logic [2:0]            x_rpt,
  input  logic [2:0]            y_rpt,
  input  logic [4*PHASES-1:0]   sl_l_str,
  input  logic [4*PHASES-1:0]   sl_c_str,
  input  logic [PHASES-1:0]     sl_l_ovl,
  input  logic [PHASES-1:0]     sl_c_ovl,
  input  logic                  sl_method,
  input  logic                  mask_en,
  input  logic [10:0]           mask_x0,
  input  logic [10:0]           mask_x1,
  input  logic [10:0]           mask_y0,
  input  logic [10:0]           mask_y1,
  input  logic [3*BPC-1:0]      border_rgb,
  output logic [BPC-1:0]        R_o,
  output logic [BPC-1:0]        G_o,
  output logic [BPC-1:0]        B_o,
  output logic                  HSYNC_o,
  output logic                  VSYNC_o,
  output logic                  DE_o,
  output logic [10:0]           xpos_o,
  output logic [10:0]           ypos_o
);

  localparam int SBW = 25;
  localparam logic [SBW-1:0] SB_RST = {2'b11, 23'd0};
  localparam logic [2:0] PMAX = 3'(PHASES - 1);

  typedef struct packed {
    logic [2:0]              xr;
    logic [2:0]              yr;
    logic [4*PHASES-1:0]     l_str;
    logic [4*PHASES-1:0]     c_str;
    logic [PHASES-1:0]       l_ovl;
    logic [PHASES-1:0]       c_ovl;
    logic                    method;
    logic                    mask_en;
    logic [10:0]             x0;
    logic [10:0]             x1;
    logic [10:0]             y0;
    logic [10:0]             y1;
    logic [2:0][BPC-1:0]     border;
  } cfg_t;

  // 4-bit strength s maps to ((s+1) << (BPC-4)) - 1, i.e. s in the MSBs with ones below.
  function automatic logic [BPC-1:0] expand_str(input logic [3:0] s);
    logic [BPC:0] t;
    t = {{(BPC-3){1'b0}}, s} + {{BPC{1'b0}}, 1'b1};
    t = t << (BPC - 4);
    t = t - {{BPC{1'b0}}, 1'b1};
    return t[BPC-1:0];
  endfunction

  function automatic logic [BPC-1:0] sat_sub(input logic [BPC-1:0] c, input logic [BPC-1:0] s);
    return (c > s) ? c - s : '0;
  endfunction

  function automatic logic [BPC-1:0] scale_mul(input logic [BPC-1:0] c, input logic [BPC-1:0] s);
    logic [2*BPC-1:0] prod;
    prod = {{BPC{1'b0}}, c} * {{BPC{1'b0}}, ~s};
    return prod[2*BPC-1:BPC];
  endfunction

  cfg_t                cfg_d, cfg_q;
  logic                vs_prev_d, vs_prev_q, de_prev_d, de_prev_q;
  logic [2:0]          x_ctr_d, x_ctr_q, y_ctr_d, y_ctr_q;
  logic                vs_fall, de_rise, de_fall;
  logic [2:0]          x_ph, ly;
  logic                l_hit, c_hit;
  logic [3:0]          l_s, c_s;

  logic [2:0][BPC-1:0] pix_p1_d, pix_p1_q, pix_p2_d, pix_p2_q, pix_p3_d, pix_p3_q;
  logic [2:0][BPC-1:0] sub_p3_d, sub_p3_q, mul_p3_d, mul_p3_q, rgb_o_d, rgb_o_q;
  logic [SBW-1:0]      sb_p1_d, sb_p1_q, sb_p2_d, sb_p2_q, sb_p3_d, sb_p3_q, sb_o_d, sb_o_q;
  logic [2:0]          xph_p1_d, xph_p1_q, ly_p1_d, ly_p1_q;
  logic                msk_p1_d, msk_p1_q, msk_p2_d, msk_p2_q, msk_p3_d, msk_p3_q;
  logic                draw_p2_d, draw_p2_q, draw_p3_d, draw_p3_q;
  logic [BPC-1:0]      str_p2_d, str_p2_q;

`ifdef SL_ALT_FIELD_EN
  logic                field_d, field_q;
`else
  logic                unused_field;
  assign unused_field = field_i;
`endif

  always_comb begin
    vs_fall   = vs_prev_q & ~VSYNC_i;
    de_rise   = DE_i & ~de_prev_q;
    de_fall   = de_prev_q & ~DE_i;
    vs_prev_d = VSYNC_i;
    de_prev_d = DE_i;

    cfg_d = cfg_q;
    if (vs_fall) begin
      cfg_d.xr      = (x_rpt > PMAX) ? PMAX : x_rpt;
      cfg_d.yr      = (y_rpt > PMAX) ? PMAX : y_rpt;
      cfg_d.l_str   = sl_l_str;
      cfg_d.c_str   = sl_c_str;
      cfg_d.l_ovl   = sl_l_ovl;
      cfg_d.c_ovl   = sl_c_ovl;
      cfg_d.method  = sl_method;
      cfg_d.mask_en = mask_en;
      cfg_d.x0      = mask_x0;
      cfg_d.x1      = mask_x1;
      cfg_d.y0      = mask_y0;
      cfg_d.y1      = mask_y1;
      cfg_d.border  = border_rgb;
    end

    // Wrap with >= so a counter left above a newly shrunk repeat still recovers.
    x_ph    = de_rise ? 3'd0 : x_ctr_q;
    x_ctr_d = x_ctr_q;
    if (DE_i) x_ctr_d = (x_ph >= cfg_q.xr) ? 3'd0 : x_ph + 3'd1;
    y_ctr_d = y_ctr_q;
    if (vs_fall)      y_ctr_d = 3'd0;
    else if (de_fall) y_ctr_d = (y_ctr_q >= cfg_q.yr) ? 3'd0 : y_ctr_q + 3'd1;
    ly = y_ctr_q;
`ifdef SL_ALT_FIELD_EN
    field_d = vs_fall ? field_i : field_q;
    if (field_q) ly = (y_ctr_q >= cfg_q.yr) ? 3'd0 : y_ctr_q + 3'd1;
`endif

    // Stage 1: capture pixel, syncs, phases and window test
    pix_p1_d = {R_i, G_i, B_i};
    sb_p1_d  = {HSYNC_i, VSYNC_i, DE_i, xpos_i, ypos_i};
    xph_p1_d = x_ph;
    ly_p1_d  = ly;
    msk_p1_d = cfg_q.mask_en & ((xpos_i < cfg_q.x0) | (xpos_i >= cfg_q.x1) |
                                (ypos_i < cfg_q.y0) | (ypos_i >= cfg_q.y1));

    // Stage 2: pick strength, line scanline over column scanline
    l_hit = 1'b0;
    l_s   = 4'd0;
    c_hit = 1'b0;
    c_s   = 4'd0;
    for (int p = 0; p < PHASES; p++) begin
      if (ly_p1_q == 3'(p)) begin
        l_hit = cfg_q.l_ovl[p];
        l_s   = cfg_q.l_str[4*p +: 4];
      end
      if (xph_p1_q == 3'(p)) begin
        c_hit = cfg_q.c_ovl[p];
        c_s   = cfg_q.c_str[4*p +: 4];
      end
    end
    pix_p2_d  = pix_p1_q;
    sb_p2_d   = sb_p1_q;
    msk_p2_d  = msk_p1_q;
    draw_p2_d = l_hit | c_hit;
    str_p2_d  = expand_str(l_hit ? l_s : c_s);

    // Stage 3: both darkening methods per channel
    sub_p3_d = '0;
    mul_p3_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sub_p3_d[ch] = sat_sub(pix_p2_q[ch], str_p2_q);
      mul_p3_d[ch] = scale_mul(pix_p2_q[ch], str_p2_q);
    end
    pix_p3_d  = pix_p2_q;
    sb_p3_d   = sb_p2_q;
    msk_p3_d  = msk_p2_q;
    draw_p3_d = draw_p2_q;

    // Stage 4: final select
    rgb_o_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (msk_p3_q)       rgb_o_d[ch] = cfg_q.border[ch];
      else if (draw_p3_q) rgb_o_d[ch] = cfg_q.method ? sub_p3_q[ch] : mul_p3_q[ch];
      else                rgb_o_d[ch] = pix_p3_q[ch];
    end
    sb_o_d = sb_p3_q;
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q     <= '0;
      vs_prev_q <= 1'b1;
      de_prev_q <= 1'b0;
      x_ctr_q   <= 3'd0;
      y_ctr_q   <= 3'd0;
      pix_p1_q  <= '0;
      sb_p1_q   <= SB_RST;
      xph_p1_q  <= 3'd0;
      ly_p1_q   <= 3'd0;
      msk_p1_q  <= 1'b0;
      pix_p2_q  <= '0;
      sb_p2_q   <= SB_RST;
      msk_p2_q  <= 1'b0;
      draw_p2_q <= 1'b0;
      str_p2_q  <= '0;
      pix_p3_q  <= '0;
      sub_p3_q  <= '0;
      mul_p3_q  <= '0;
      sb_p3_q   <= SB_RST;
      msk_p3_q  <= 1'b0;
      draw_p3_q <= 1'b0;
      rgb_o_q   <= '0;
      sb_o_q    <= SB_RST;
`ifdef SL_ALT_FIELD_EN
      field_q   <= 1'b0;
`endif
    end else begin
      cfg_q     <= cfg_d;
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      x_ctr_q   <= x_ctr_d;
      y_ctr_q   <= y_ctr_d;
      pix_p1_q  <= pix_p1_d;
      sb_p1_q   <= sb_p1_d;
      xph_p1_q  <= xph_p1_d;
      ly_p1_q   <= ly_p1_d;
      msk_p1_q  <= msk_p1_d;
      pix_p2_q  <= pix_p2_d;
      sb_p2_q   <= sb_p2_d;
      msk_p2_q  <= msk_p2_d;
      draw_p2_q <= draw_p2_d;
      str_p2_q  <= str_p2_d;
      pix_p3_q  <= pix_p3_d;
      sub_p3_q  <= sub_p3_d;
      mul_p3_q  <= mul_p3_d;
      sb_p3_q   <= sb_p3_d;
      msk_p3_q  <= msk_p3_d;
      draw_p3_q <= draw_p3_d;
      rgb_o_q   <= rgb_o_d;
      sb_o_q    <= sb_o_d;
`ifdef SL_ALT_FIELD_EN
      field_q   <= field_d;
`endif
    end
  end

  assign {R_o, G_o, B_o} = rgb_o_q;
  assign {HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o} = sb_o_q;

endmodule

// File: tb/tb_scanline_pp_engine.sv
// Scoreboard bench for scanline_pp_engine (BPC=8, PHASES=6): frame generator plus reference model.
module tb_scanline_pp_engine;

  logic        clk, reset_n;
  logic [7:0]  R_i, G_i, B_i, R_o, G_o, B_o;
  logic        HSYNC_i, VSYNC_i, DE_i, field_i, HSYNC_o, VSYNC_o, DE_o;
  logic [10:0] xpos_i, ypos_i, xpos_o, ypos_o;
  logic [2:0]  x_rpt, y_rpt;
  logic [23:0] sl_l_str, sl_c_str, border_rgb;
  logic [5:0]  sl_l_ovl, sl_c_ovl;
  logic        sl_method, mask_en;
  logic [10:0] mask_x0, mask_x1, mask_y0, mask_y1;

  scanline_pp_engine #(.BPC(8), .PHASES(6)) dut (
    .PCLK_i(clk), .reset_n(reset_n),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .xpos_i(xpos_i), .ypos_i(ypos_i), .field_i(field_i),
    .x_rpt(x_rpt), .y_rpt(y_rpt),
    .sl_l_str(sl_l_str), .sl_c_str(sl_c_str), .sl_l_ovl(sl_l_ovl), .sl_c_ovl(sl_c_ovl),
    .sl_method(sl_method), .mask_en(mask_en),
    .mask_x0(mask_x0), .mask_x1(mask_x1), .mask_y0(mask_y0), .mask_y1(mask_y1),
    .border_rgb(border_rgb),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
    .xpos_o(xpos_o), .ypos_o(ypos_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SL_ALT_FIELD_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  typedef struct packed {
    logic        chk;
    logic [24:0] sb;
    logic [23:0] rgb;
  } exp_t;

  exp_t  sbq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_test = "init";

  int          m_xr, m_yr, m_x0, m_x1, m_y0, m_y1;
  logic [23:0] m_l_str, m_c_str, m_border;
  logic [5:0]  m_l_ovl, m_c_ovl;
  logic        m_method, m_mask_en, m_field;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic latch_model();
    m_xr = (x_rpt > 3'd5) ? 5 : int'(x_rpt);
    m_yr = (y_rpt > 3'd5) ? 5 : int'(y_rpt);
    m_l_str = sl_l_str;  m_c_str = sl_c_str;
    m_l_ovl = sl_l_ovl;  m_c_ovl = sl_c_ovl;
    m_method = sl_method; m_mask_en = mask_en; m_field = field_i;
    m_x0 = int'(mask_x0); m_x1 = int'(mask_x1);
    m_y0 = int'(mask_y0); m_y1 = int'(mask_y1);
    m_border = border_rgb;
  endtask

  function automatic logic [23:0] pix(input int line, input int col);
    logic [7:0] tbl [4];
    tbl = '{8'hC8, 8'h30, 8'hFF, 8'h00};
    return {tbl[(col + line) % 4], 8'(col * 37 + line), 8'(line * 53 + 7)};
  endfunction

  // Reference: phases from the bench's own line/column indices.
  function automatic logic [23:0] model_px(input logic [23:0] px, input int line, input int col);
    int ly, xp, s, str, c;
    logic [23:0] o;
    ly = line % (m_yr + 1);
    if (ALT && m_field) ly = (line + 1) % (m_yr + 1);
    xp = col % (m_xr + 1);
    if (m_mask_en && (col < m_x0 || col >= m_x1 || line < m_y0 || line >= m_y1)) return m_border;
    if (m_l_ovl[ly])      s = int'(m_l_str[4*ly +: 4]);
    else if (m_c_ovl[xp]) s = int'(m_c_str[4*xp +: 4]);
    else return px;
    str = s * 16 + 15;
    for (int ch = 0; ch < 3; ch++) begin
      c = int'(px[8*ch +: 8]);
      if (m_method) o[8*ch +: 8] = (c > str) ? 8'(c - str) : 8'd0;
      else          o[8*ch +: 8] = 8'((c * (255 - str)) >> 8);
    end
    return o;
  endfunction

  task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y,
                      input logic [23:0] px, input logic chk, input logic [23:0] erg);
    exp_t e;
    @(posedge clk); #1;
    if (sbq.size() >= 4) begin
      e = sbq.pop_front();
      check_eq({cur_test, "_sync"}, 32'({HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o}), 32'(e.sb));
      if (e.chk) check_eq({cur_test, "_pixel"}, 32'({R_o, G_o, B_o}), 32'(e.rgb));
    end
    HSYNC_i = hs; VSYNC_i = vs; DE_i = de;
    xpos_i = 11'(x); ypos_i = 11'(y);
    {R_i, G_i, B_i} = px;
    e.chk = chk;
    e.sb  = {hs, vs, de, 11'(x), 11'(y)};
    e.rgb = erg;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b1, 1'b0, 0, 0, 24'h0, 1'b0, 24'h0);
  endtask

  task automatic vsync_start(input bit tight);
    if (!tight) idle(2);
    latch_model();
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 24'h0, 1'b0, 24'h0);
    idle(2);
  endtask

  task automatic line_px(input int line, input int c0, input int c1, input logic chk);
    for (int col = c0; col < c1; col++)
      step(1'b1, 1'b1, 1'b1, col, line, pix(line, col), chk, model_px(pix(line, col), line, col));
  endtask

  task automatic run_frame(input int nlines, input int npix, input bit tight, input int chg_line);
    vsync_start(tight);
    for (int line = 0; line < nlines; line++) begin
      if (line == chg_line) begin
        mask_x0 = 11'd0; mask_x1 = 11'd4; mask_y0 = 11'd2; mask_y1 = 11'd4;
        border_rgb = 24'h204060;
      end
      step(1'b0, 1'b1, 1'b0, 0, 0, 24'h0, 1'b0, 24'h0);
      idle(2);
      line_px(line, 0, npix, 1'b1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_R"}, 32'(R_o), 32'h0);
    check_eq({tag, "_G"}, 32'(G_o), 32'h0);
    check_eq({tag, "_B"}, 32'(B_o), 32'h0);
    check_eq({tag, "_DE"}, 32'(DE_o), 32'h0);
    check_eq({tag, "_HS"}, 32'(HSYNC_o), 32'h1);
    check_eq({tag, "_VS"}, 32'(VSYNC_o), 32'h1);
    check_eq({tag, "_pos"}, 32'({xpos_o, ypos_o}), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    {R_i, G_i, B_i} = 24'h0;
    HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b0; field_i = 1'b0;
    xpos_i = '0; ypos_i = '0;
    x_rpt = '0; y_rpt = '0; sl_l_str = '0; sl_c_str = '0; sl_l_ovl = '0; sl_c_ovl = '0;
    sl_method = 1'b0; mask_en = 1'b0;
    mask_x0 = '0; mask_x1 = '0; mask_y0 = '0; mask_y1 = '0; border_rgb = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(posedge clk); #1 reset_n = 1'b1;

    cur_test = "pass";      run_frame(3, 8, 0, -1);

    cur_test = "scan_sub";
    y_rpt = 3'd1; sl_l_ovl = 6'b000010; sl_l_str = 24'h000030; sl_method = 1'b1;
    run_frame(4, 8, 0, -1);
    cur_test = "scan_mul";  sl_method = 1'b0; run_frame(4, 8, 0, -1);

    cur_test = "col";
    sl_l_ovl = '0; x_rpt = 3'd2; sl_c_ovl = 6'b000100; sl_c_str = 24'h000F00;
    run_frame(3, 12, 0, -1);

    cur_test = "clamp";
    x_rpt = 3'd7; y_rpt = 3'd7; sl_c_ovl = 6'b100000; sl_c_str = 24'hA00000;
    sl_l_ovl = 6'b000001; sl_l_str = 24'h000005; sl_method = 1'b1;
    run_frame(7, 14, 0, -1);

    cur_test = "prio";
    x_rpt = 3'd1; y_rpt = 3'd1; sl_l_ovl = 6'b000010; sl_l_str = 24'h000020;
    sl_c_ovl = 6'b000011; sl_c_str = 24'h000088;
    run_frame(4, 6, 0, -1);

    cur_test = "mask";
    x_rpt = '0; y_rpt = '0; sl_l_ovl = '0; sl_c_ovl = '0;
    mask_en = 1'b1; mask_x0 = 11'd10; mask_x1 = 11'd20; mask_y0 = 11'd5; mask_y1 = 11'd8;
    border_rgb = 24'h101010;
    run_frame(9, 22, 0, 3);
    cur_test = "mask_chg";  run_frame(5, 8, 0, -1);

    cur_test = "mask_empty";
    mask_x0 = 11'd15; mask_x1 = 11'd15; mask_y0 = 11'd0; mask_y1 = 11'd100;
    run_frame(2, 8, 0, -1);

    cur_test = "field1";
    mask_en = 1'b0; y_rpt = 3'd1; sl_l_ovl = 6'b000010; sl_l_str = 24'h000030; sl_method = 1'b1;
    field_i = 1'b1; run_frame(4, 6, 0, -1);
    cur_test = "field0";    field_i = 1'b0; run_frame(3, 6, 0, -1);

    cur_test = "vs_de_fall"; run_frame(4, 6, 1, -1);

    cur_test = "de1";
    x_rpt = 3'd2; sl_l_ovl = '0; sl_c_ovl = 6'b000001; sl_c_str = 24'h00000F;
    run_frame(4, 1, 0, -1);

    cur_test = "midreset";
    x_rpt = '0; y_rpt = 3'd1; sl_c_ovl = '0; sl_l_ovl = 6'b000010; sl_l_str = 24'h000030;
    vsync_start(0);
    line_px(0, 0, 6, 1'b1);
    idle(2);
    line_px(1, 0, 3, 1'b1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sbq.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    line_px(1, 3, 6, 1'b0);
    cur_test = "recover";   run_frame(3, 8, 0, -1);

    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
